// File: rtl/fetch_pkg.sv
// Definitions shared by the fetch stage and the decoder: FSM states,
// the opcodes that carry a trailing immediate word, and has_imm().
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    FETCH_OP  = 2'd1,
    FETCH_IMM = 2'd2,
    VALID     = 2'd3
  } fetch_state_t;

  localparam logic [6:0] OP_LDD = 7'h02;
  localparam logic [6:0] OP_LDO = 7'h03;
  localparam logic [6:0] OP_LDI = 7'h04;
  localparam logic [6:0] OP_STD = 7'h05;
  localparam logic [6:0] OP_STO = 7'h06;
  localparam logic [6:0] OP_ADI = 7'h08;
  localparam logic [6:0] OP_CMI = 7'h0D;
  localparam logic [6:0] OP_JMP = 7'h0E;

  function automatic logic has_imm(input logic [6:0] opcode);
    case (opcode)
      OP_LDD, OP_LDO, OP_LDI, OP_STD, OP_STO, OP_ADI, OP_CMI, OP_JMP: has_imm = 1'b1;
      default: has_imm = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, opcode/immediate fetch FSM and decode handshake.
// Optional memory stall counter is enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W         = 16,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_req,
  input  logic            mem_ack,
  input  logic [15:0]     mem_data,
  output logic [15:0]     instr,
  output logic [15:0]     imm,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            pc_inc,
  input  logic            pc_ie,
  input  logic [PC_W-1:0] pc_load,
  output logic [PC_W-1:0] pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  fetch_state_t    state, next_state;
  logic [PC_W-1:0] pc_step;

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    mem_req     = 1'b0;
    mem_addr    = pc;
    instr_valid = 1'b0;
    case (state)
      BOOT: next_state = FETCH_OP;
      FETCH_OP: begin
        mem_req = 1'b1;
        if (mem_ack) next_state = has_imm(mem_data[15:9]) ? FETCH_IMM : VALID;
      end
      FETCH_IMM: begin
        mem_req  = 1'b1;
        mem_addr = pc + PC_W'(1);
        if (mem_ack) next_state = VALID;
      end
      VALID: begin
        instr_valid = 1'b1;
        if (instr_ready) next_state = FETCH_OP;
      end
      default: next_state = BOOT;
    endcase
  end

  // The held instruction word tells us whether it occupied one or two memory words.
  assign pc_step = has_imm(instr[15:9]) ? PC_W'(2) : PC_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_VECTOR;
      instr <= 16'h0000;
      imm   <= 16'h0000;
    end else begin
      case (state)
        FETCH_OP: begin
          if (mem_ack) begin
            instr <= mem_data;
            if (!has_imm(mem_data[15:9])) imm <= 16'h0000;
          end
        end
        FETCH_IMM: begin
          if (mem_ack) imm <= mem_data;
        end
        VALID: begin
          if (instr_ready) begin
            if (pc_ie)       pc <= pc_load;
            else if (pc_inc) pc <= pc + pc_step;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= 16'h0000;
    else if (mem_req && !mem_ack && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decoder. Holds the program counter and fetches 16-bit instruction words from program memory over a req/ack handshake. Fetches a trailing immediate word for opcodes that use the ALU immediate operand, then presents `instr`/`imm` to decode/execute with a valid/ready handshake. Applies the decoder's `pc_inc`/`pc_ie` controls to select the next fetch address.

## Interface
- `PC_W`, 16: program counter and memory address width.
- `RESET_VECTOR`, 16'h0000: PC value after reset.

- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `mem_addr`  out  PC_W: program memory word address.
- `mem_req`  out  1: fetch request; `mem_addr` stable while high.
- `mem_ack`  in  1: memory accepts request; `mem_data` valid in the same cycle.
- `mem_data`  in  16: fetched word.
- `instr`  out  16: current instruction word to decoder.
- `imm`  out  16: immediate word (0 when the opcode has none).
- `instr_valid`  out  1: `instr`/`imm` valid.
- `instr_ready`  in  1: execute retires the current instruction this cycle.
- `pc_inc`  in  1: decoder control, advance sequentially.
- `pc_ie`  in  1: decoder control, load `pc_load`.
- `pc_load`  in  PC_W: jump target (ALU result).
- `pc`  out  PC_W: address of the current instruction.
- `stall_cnt`  out  16: memory stall cycles (only with `FETCH_STALL_CNT_EN`).

## Operation
- States: BOOT, FETCH_OP, FETCH_IMM, VALID.
- BOOT: `mem_req`=0, then FETCH_OP unconditionally.
- FETCH_OP: `mem_req`=1, `mem_addr`=`pc`. On `mem_ack`, latch `mem_data` into `instr`. If `has_imm(mem_data[15:9])`, go to FETCH_IMM. Otherwise set `imm`=0 and go to VALID.
- Immediate opcodes (bits 15:9): 0x02 ldd, 0x03 ldo, 0x04 ldi, 0x05 std, 0x06 sto, 0x08 adi, 0x0D cmi, 0x0E jmp.
- FETCH_IMM: `mem_req`=1, `mem_addr`=`pc`+1 (mod 2^PC_W). On `mem_ack`, latch `imm`, go to VALID.
- VALID: `instr_valid`=1, `mem_req`=0. On `instr_ready`:
  - `pc_ie`=1: `pc` <= `pc_load`. `pc_ie` wins over `pc_inc`.
  - else `pc_inc`=1: `pc` <= `pc`+1, or +2 if the instruction had an immediate; wraps modulo 2^PC_W.
  - else `pc` is unchanged and the same instruction is refetched.
  - In all three cases, go to FETCH_OP.
- `mem_ack` outside FETCH_OP/FETCH_IMM is ignored.
- `instr`/`imm` hold their values outside the latch events.
- `mem_req` is decoded from state; `instr_valid` = (state==VALID).

## Timing
- Reset values: `pc`=RESET_VECTOR, `instr`=0, `imm`=0, `instr_valid`=0, `mem_req`=0, `mem_addr`=RESET_VECTOR, `stall_cnt`=0, state=BOOT.
- Reset mid-fetch: any outstanding ack is dropped. `mem_req` is low in the cycle after `rst` is sampled high.
- `mem_ack` may arrive in the first cycle `mem_req` is high; `mem_req` drops the next cycle.
- Minimum cycles from FETCH_OP entry to `instr_valid`: 1 without immediate, 2 with immediate. Each stall cycle adds 1.
- Minimum throughput: 2 cycles per plain instruction, 3 per immediate instruction (with `instr_ready` tied high).
- `pc_inc`/`pc_ie`/`pc_load` are sampled only in VALID with `instr_ready`=1.

## Configuration
- `FETCH_STALL_CNT_EN` defined:
  - `stall_cnt` port exists.
  - It increments every cycle with `mem_req`=1 and `mem_ack`=0.
  - It saturates at 16'hFFFF and is cleared only by `rst`.
- Not defined: port and counter are absent; all other behaviour is identical.

## Structure
- Package `fetch_pkg`: state enum (BOOT, FETCH_OP, FETCH_IMM, VALID), the 7-bit opcode constants listed above, and function `has_imm(opcode)`.
- The decoder shares the same opcode constants.
- No sub-module: a single module holding the FSM, PC register and optional counter.

## Test plan
- Reset, `mem_ack` tied high, memory[0]=16'h0E40 (add): `mem_req` low for 1 cycle after reset, then addr 0. `instr_valid` with `instr`=16'h0E40, `imm`=0. With `pc_inc`=1 the next fetch is addr 1.
- memory[4]=16'h0840 (ldi), memory[5]=16'h1234, `pc`=4: fetches addr 4 then addr 5. Presents `imm`=16'h1234. With `pc_inc`, the next `pc`=6.
- jmp at addr 8 with `pc_ie`=1, `pc_inc`=1, `pc_load`=16'h0100: `pc_ie` wins, the next fetch is addr 16'h0100, not 10.
- `pc`=16'hFFFF, immediate instruction: the immediate is fetched from addr 0. With `pc_inc`, the next `pc`=1.
- `mem_ack` delayed 3 cycles on the opcode fetch: `mem_addr` stays stable while `mem_req` is high, and `instr_valid` appears 1 cycle after the ack. With the macro, `stall_cnt` increases by 3.
- `rst` asserted during FETCH_IMM with `mem_ack` high in the same cycle: `imm` is not updated. All outputs return to reset values and the fetch restarts at RESET_VECTOR.
